// File: rtl/lms_adapt_ctrl.sv
// LMS adaptation controller: sequences coefficient init, schedules mu (acquisition/tracking),
// strobes coefficient updates and tracks lock from a windowed sum of |e|.
module lms_adapt_ctrl #(
    parameter int              NBe        = 9,
    parameter int              NBmu       = 8,
    parameter logic [NBmu-1:0] MU_ACQ     = 8'h10,
    parameter logic [NBmu-1:0] MU_TRK     = 8'h04,
    parameter int              ACQ_LEN    = 600,
    parameter int              UPD_DIV    = 2,
    parameter int              WIN_LOG2   = 6,
    parameter int              LOCK_THR   = 256,
    parameter int              UNLOCK_THR = 1024,
    localparam int             EPW        = NBe - 1 + WIN_LOG2
) (
    input  logic                  clkA,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  freeze,
    input  logic signed [NBe-1:0] e,
    input  logic                  e_valid,
    output logic [NBmu-1:0]       mu,
    output logic                  upd_en,
    output logic                  coeff_init,
    output logic [1:0]            state,
    output logic                  locked,
    output logic [EPW-1:0]        err_pow
);

    localparam int AW = $clog2(ACQ_LEN + 1);
    localparam int DW = $clog2(UPD_DIV + 1);
    localparam logic [NBe-1:0] E_MIN    = {1'b1, {(NBe-1){1'b0}}};
    localparam logic [EPW-1:0] LOCK_T   = EPW'(LOCK_THR);
    localparam logic [EPW-1:0] UNLOCK_T = EPW'(UNLOCK_THR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_ACQ   = 2'd2,
        S_TRACK = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NBmu-1:0]   mu_q, mu_d;
    logic              upd_q, upd_d;
    logic              cinit_q, cinit_d;
    logic              locked_q, locked_d;
    logic [EPW-1:0]    errpow_q, errpow_d;
    logic [EPW-1:0]    acc_q, acc_d;
    logic [AW-1:0]     acq_q, acq_d;
    logic [WIN_LOG2-1:0] win_q, win_d;
    logic [DW-1:0]     div_q, div_d;

    logic [NBe-2:0]    mag;
    logic [EPW-1:0]    sum;
    logic              smp;
    logic              win_end;

    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mu_q     <= '0;
            upd_q    <= 1'b0;
            cinit_q  <= 1'b0;
            locked_q <= 1'b0;
            errpow_q <= '0;
            acc_q    <= '0;
            acq_q    <= '0;
            win_q    <= '0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            mu_q     <= mu_d;
            upd_q    <= upd_d;
            cinit_q  <= cinit_d;
            locked_q <= locked_d;
            errpow_q <= errpow_d;
            acc_q    <= acc_d;
            acq_q    <= acq_d;
            win_q    <= win_d;
            div_q    <= div_d;
        end
    end

    always_comb begin
        // Most-negative e has no positive twin; clamp to the largest magnitude.
        if (e == E_MIN)       mag = '1;
        else if (e[NBe-1])    mag = (NBe-1)'(-e);
        else                  mag = e[NBe-2:0];
        sum     = acc_q + EPW'(mag);
        smp     = e_valid && (state_q == S_ACQ || state_q == S_TRACK);
        win_end = smp && (win_q == '1);

        state_d  = state_q;
        upd_d    = 1'b0;
        locked_d = locked_q;
        errpow_d = errpow_q;
        acc_d    = acc_q;
        acq_d    = acq_q;
        win_d    = win_q;
        div_d    = div_q;

        if (start) begin
            state_d  = S_INIT;
            locked_d = 1'b0;
        end else if (stop) begin
            state_d  = S_IDLE;
            locked_d = 1'b0;
        end else if (state_q == S_INIT) begin
            state_d  = S_ACQ;
            acq_d    = '0;
            acc_d    = '0;
            win_d    = '0;
            div_d    = '0;
            locked_d = 1'b0;
        end else if (smp) begin
            if (div_q == DW'(UPD_DIV - 1)) begin
                div_d = '0;
                upd_d = !freeze;
            end else begin
                div_d = div_q + 1'b1;
            end

            if (win_end) begin
                errpow_d = sum;
                acc_d    = '0;
                win_d    = '0;
                if (sum <= LOCK_T)       locked_d = 1'b1;
                else if (sum > UNLOCK_T) locked_d = 1'b0;
            end else begin
                acc_d = sum;
                win_d = win_q + 1'b1;
            end

            if (state_q == S_ACQ && !freeze) begin
                if (acq_q == AW'(ACQ_LEN - 1)) begin
                    state_d = S_TRACK;
                    acq_d   = '0;
                end else begin
                    acq_d = acq_q + 1'b1;
                end
            end else if (state_q == S_TRACK && win_end && sum > UNLOCK_T && !freeze) begin
                state_d = S_ACQ;
                acq_d   = '0;
            end
        end

        cinit_d = (state_d == S_INIT);
        case (state_d)
            S_ACQ:   mu_d = MU_ACQ;
            S_TRACK: mu_d = MU_TRK;
            default: mu_d = '0;
        endcase
    end

    assign state      = state_q;
    assign mu         = mu_q;
    assign upd_en     = upd_q;
    assign coeff_init = cinit_q;
    assign locked     = locked_q;
    assign err_pow    = errpow_q;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Bench for lms_adapt_ctrl: directed steps then random stimulus against a behavioural model.
module tb_lms_adapt_ctrl;

    localparam int NBE = 9;
    localparam int WL  = 2;
    localparam int EPW = NBE - 1 + WL;
    localparam int ACQ = 8;
    localparam int DIV = 2;
    localparam int LTH = 16;
    localparam int UTH = 40;

    logic           clkA = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0, stop = 1'b0, freeze = 1'b0, e_valid = 1'b0;
    logic [NBE-1:0] e = '0;
    logic [7:0]     mu;
    logic           upd_en, coeff_init, locked;
    logic [1:0]     state;
    logic [EPW-1:0] err_pow;

    int checks = 0;
    int failures = 0;

    // model state
    int m_state, m_acq, m_div, m_locked, m_err, m_upd, m_cinit, m_mu;
    int m_win[$];

    lms_adapt_ctrl #(
        .NBe(NBE), .NBmu(8), .MU_ACQ(8'h10), .MU_TRK(8'h04), .ACQ_LEN(ACQ),
        .UPD_DIV(DIV), .WIN_LOG2(WL), .LOCK_THR(LTH), .UNLOCK_THR(UTH)
    ) dut (
        .clkA(clkA), .reset(reset), .start(start), .stop(stop), .freeze(freeze),
        .e($signed(e)), .e_valid(e_valid), .mu(mu), .upd_en(upd_en),
        .coeff_init(coeff_init), .state(state), .locked(locked), .err_pow(err_pow)
    );

    always #5 clkA = ~clkA;

    task automatic model_reset();
        m_state = 0; m_acq = 0; m_div = 0; m_locked = 0; m_err = 0;
        m_upd = 0; m_cinit = 0; m_mu = 0;
        m_win.delete();
    endtask

    task automatic model_step();
        int nstate, a, s;
        bit wend;
        nstate = m_state;
        m_upd  = 0;
        wend   = 0;
        s      = 0;
        if (start) begin
            nstate = 1; m_locked = 0;
        end else if (stop) begin
            nstate = 0; m_locked = 0;
        end else if (m_state == 1) begin
            nstate = 2; m_acq = 0; m_div = 0; m_locked = 0; m_win.delete();
        end else if (m_state >= 2 && e_valid) begin
            a = $signed(e);
            if (a < 0) a = -a;
            if (a > 255) a = 255;
            m_div = (m_div + 1) % DIV;
            if (m_div == 0 && !freeze) m_upd = 1;
            m_win.push_back(a);
            if (m_win.size() == (1 << WL)) begin
                foreach (m_win[i]) s += m_win[i];
                m_win.delete();
                m_err = s;
                wend  = 1;
                if (s <= LTH) m_locked = 1;
                else if (s > UTH) m_locked = 0;
            end
            if (m_state == 2 && !freeze) begin
                m_acq++;
                if (m_acq == ACQ) begin nstate = 3; m_acq = 0; end
            end else if (m_state == 3 && wend && s > UTH && !freeze) begin
                nstate = 2; m_acq = 0;
            end
        end
        m_state = nstate;
        m_cinit = (nstate == 1);
        m_mu    = (nstate == 2) ? 'h10 : (nstate == 3) ? 'h04 : 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},   32'(state),      32'(m_state));
        check({tag, ".mu"},      32'(mu),         32'(m_mu));
        check({tag, ".upd_en"},  32'(upd_en),     32'(m_upd));
        check({tag, ".cinit"},   32'(coeff_init), 32'(m_cinit));
        check({tag, ".locked"},  32'(locked),     32'(m_locked));
        check({tag, ".err_pow"}, 32'(err_pow),    32'(m_err));
    endtask

    task automatic step(input string tag, input bit st, input bit sp, input bit fr,
                        input bit ev, input int ev_val);
        start = st; stop = sp; freeze = fr; e_valid = ev; e = NBE'(ev_val);
        @(posedge clkA);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("rst");
        #10 reset = 1'b1;
        @(posedge clkA); #1;
        step("idle", 0, 0, 0, 1, 3);

        // 1: acquisition with e=2
        step("t1.start", 0 + 1, 0, 0, 1, 2);
        for (int i = 0; i < 13; i++) step("t1.run", 0, 0, 0, 1, 2);
        check("t1.track", 32'(state), 32'd3);
        check("t1.errpow", 32'(err_pow), 32'd8);
        check("t1.locked", 32'(locked), 32'd1);

        // 2: large error in TRACK triggers re-acquire
        for (int i = 0; i < 4; i++) step("t2.unlock", 0, 0, 0, 1, -12);
        check("t2.errpow", 32'(err_pow), 32'd48);
        check("t2.state", 32'(state), 32'd2);
        check("t2.locked", 32'(locked), 32'd0);
        check("t2.mu", 32'(mu), 32'h10);

        // 3: freeze in ACQ delays TRACK entry
        for (int i = 0; i < 5; i++) step("t3.frz", 0, 0, 1, 1, 1);
        for (int i = 0; i < 7; i++) step("t3.run", 0, 0, 0, 1, 1);
        check("t3.still_acq", 32'(state), 32'd2);
        step("t3.last", 0, 0, 0, 1, 1);
        check("t3.track", 32'(state), 32'd3);

        // 4: most-negative error saturates
        step("t4.start", 1, 0, 0, 1, -256);
        step("t4.init", 0, 0, 0, 1, -256);
        for (int i = 0; i < 4; i++) step("t4.sat", 0, 0, 0, 1, -256);
        check("t4.errpow", 32'(err_pow), 32'd1020);
        check("t4.locked", 32'(locked), 32'd0);
        for (int i = 0; i < 4; i++) step("t4.zero", 0, 0, 0, 1, 0);
        check("t4.track", 32'(state), 32'd3);
        check("t4.lock", 32'(locked), 32'd1);

        // 5: start beats stop; then stop alone
        step("t5.both", 1, 1, 0, 1, 0);
        check("t5.state", 32'(state), 32'd1);
        check("t5.cinit", 32'(coeff_init), 32'd1);
        check("t5.locked", 32'(locked), 32'd0);
        check("t5.mu", 32'(mu), 32'd0);
        step("t5.stop", 0, 1, 0, 1, 0);
        check("t5.idle", 32'(state), 32'd0);
        check("t5.mu0", 32'(mu), 32'd0);

        // random phase
        for (int i = 0; i < 400; i++) begin
            int v;
            v = (($urandom_range(0, 9)) == 0) ? -256 : int'($urandom_range(0, 120)) - 60;
            step("rnd", ($urandom_range(0, 49) == 0) || i == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0, v);
        end

        // 6: asynchronous reset mid-ACQ
        step("t6.start", 1, 0, 0, 1, 5);
        for (int i = 0; i < 4; i++) step("t6.acq", 0, 0, 0, 1, 5);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_all("t6.async");
        #3 reset = 1'b1;
        for (int i = 0; i < 4; i++) step("t6.post", 0, 0, 0, 1, 5);
        check("t6.idle", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lms_adapt_ctrl.md
Name: lms_adapt_ctrl

Overview:
- Adaptation controller for the LMS equalizer coefficient-update datapath.
- Sequences coefficient re-initialisation, schedules the step size mu (acquisition, then tracking), and generates the coefficient-update enable.
- Monitors the windowed error magnitude for lock/unlock decisions.
- Sits beside the LMS block: drives its mu, update-enable and coefficient-init inputs, and consumes the error sample e.

Parameters:
- NBe, 9, error word width (signed)
- NBmu, 8, mu word width
- MU_ACQ, 8'h10, mu during acquisition (0.125 at 7 fractional bits)
- MU_TRK, 8'h04, mu during tracking (0.03125)
- ACQ_LEN, 600, valid error samples spent in acquisition
- UPD_DIV, 2, one coefficient update per UPD_DIV valid samples (>=1)
- WIN_LOG2, 6, error-metric window = 2^WIN_LOG2 valid samples
- LOCK_THR, 256, window metric <= LOCK_THR sets locked
- UNLOCK_THR, 1024, window metric > UNLOCK_THR clears locked; must exceed LOCK_THR

Ports:
- clkA  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; (re)start adaptation from INIT
- stop  in  1  pulse; return to IDLE
- freeze  in  1  level; masks updates and holds the acquisition count
- e  in  NBe  signed error sample
- e_valid  in  1  e qualifier
- mu  out  NBmu  step size to LMS
- upd_en  out  1  one-cycle coefficient-update strobe
- coeff_init  out  1  one-cycle pulse; LMS reloads its centre-tap initial coefficients
- state  out  2  IDLE=0, INIT=1, ACQ=2, TRACK=3
- locked  out  1  lock indicator
- err_pow  out  NBe-1+WIN_LOG2  last completed window sum of |e|

Behaviour:
- Reset: all registers clear asynchronously when reset is low. state=IDLE; mu=0, upd_en=0, coeff_init=0, locked=0, err_pow=0; all counters=0.
- All outputs are registered. mu is updated on the same edge as state, so mu always matches state: IDLE/INIT -> 0, ACQ -> MU_ACQ, TRACK -> MU_TRK.
- Command priority each cycle: start > stop > internal transitions.
  - start in any state -> INIT.
  - stop (without start) in any state -> IDLE; locked cleared.
- IDLE: waits; e_valid is ignored.
- INIT: exactly one cycle. coeff_init=1 during it. Clears acq_cnt, the window accumulator, the window count, the update-divider count and locked. Unconditionally -> ACQ.
- ACQ:
  - Each e_valid with freeze=0 increments acq_cnt.
  - When acq_cnt = ACQ_LEN-1 and a qualifying e_valid arrives -> TRACK on the next edge.
  - freeze=1 holds acq_cnt.
- TRACK:
  - At a window end with metric > UNLOCK_THR and freeze=0 -> ACQ (re-acquire). acq_cnt=0 and locked=0; no coeff_init.
  - With freeze=1 the re-acquire is suppressed, but locked still clears.
- Update strobe:
  - The divider counts every e_valid in ACQ/TRACK, wrapping at UPD_DIV-1.
  - upd_en=1 in the cycle after the e_valid that wraps the divider, provided freeze=0 in that e_valid cycle. Otherwise upd_en=0.
  - With UPD_DIV=1, upd_en follows e_valid delayed one cycle.
- Error metric:
  - |e| is computed with saturation: the most-negative e maps to 2^(NBe-1)-1.
  - Accumulated over 2^WIN_LOG2 valid samples in ACQ/TRACK, regardless of freeze.
  - On the last sample of a window: err_pow <= acc + |e|, acc <= 0, and the lock/unlock decision uses that same sum.
  - locked sets when sum <= LOCK_THR and clears when sum > UNLOCK_THR; between the two thresholds it holds.
  - The accumulator cannot overflow by construction.
- Simultaneous events:
  - ACQ_LEN completion and a window end on the same sample: go to TRACK, and update locked from the sum.
  - A window end in ACQ never forces a state change.
  - start during ACQ/TRACK discards the partial window. err_pow keeps its last value until the next window completes.
- Gaps in e_valid stall all counters; there is no timeout.

Test Plan:
Bench parameters: ACQ_LEN=8, UPD_DIV=2, WIN_LOG2=2, LOCK_THR=16, UNLOCK_THR=40, NBe=9.
1. Release reset, then pulse start, then drive e=2 every cycle with e_valid=1 -> coeff_init high for 1 cycle (state=1). Then state=2, mu=0x10. upd_en pulses every 2nd cycle. After the 8th valid sample, state=3 and mu=0x04. err_pow=8 after each 4 samples; locked=1 at the first window end.
2. In TRACK with locked=1, drive e=-12 for 4 samples -> err_pow=48 > 40: locked=0, state=2, mu=0x10, acq_cnt restarts. coeff_init stays 0.
3. In ACQ, hold freeze=1 for 5 valid samples -> upd_en stays 0 and acq_cnt frozen, so the TRACK entry is delayed by exactly 5 samples. err_pow keeps updating.
4. Drive e=-256 (9'h100) for 4 samples -> |e| saturates to 255, err_pow=1020, locked=0.
5. In TRACK, assert start and stop in the same cycle -> next state=1 (INIT), coeff_init=1, locked=0, mu=0. A stop pulse alone afterwards -> state=0, mu=0.
6. Assert reset low mid-ACQ, asynchronously between clock edges -> all outputs reach their reset values before the next clkA edge. After release with no start, state remains 0.
